lcd_timing_ctrl: RTL
====================

# lcd_timing_ctrl

Avalon-MM slave controller for the board's HD44780-compatible 16x2 character LCD, on the system interconnect between the Nios II data master and the LCD pins. Replaces direct pass-through of bus cycles to the panel with:
- a posted-write command/data FIFO;
- parametrised enable-pulse timing;
- automatic per-instruction execution delays;
- stalled reads via waitrequest.

Software writes bytes at full bus speed; the block paces them to the panel.

## Interface
Parameters:
- TAS_CYC, 3: clk cycles RS/RW/data setup before LCD_E rises (≥40 ns).
- PW_CYC, 12: clk cycles LCD_E high (≥230 ns).
- TH_CYC, 2: clk cycles RS/RW/data hold after LCD_E falls (≥10 ns).
- EXEC_CYC, 2500: post-access delay for ordinary instructions/data (50 µs @ 50 MHz).
- CLR_CYC, 82000: post-access delay for clear/home instructions (1.64 ms).
- FIFO_DEPTH, 8: write FIFO entries, 2..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  bit1 = RS, bit0 = RW (01/11 = panel read).
- read  in  1  Avalon read.
- write  in  1  Avalon write.
- writedata  in  8  byte to panel.
- readdata  out  8  registered read data.
- waitrequest  out  1  Avalon stall.
- LCD_E  out  1  panel enable.
- LCD_RS  out  1  panel register select.
- LCD_RW  out  1  panel read/not-write.
- LCD_data  inout  8  panel data bus, tri-stated when LCD_RW = 1.

## Operation
- Writes with address[0]=0 push {RS, byte} into the FIFO.
  - waitrequest = write & fifo_full (combinational, ignores same-cycle pop).
- Writes with address[0]=1 are accepted and discarded.
- Reads with address[0]=0 return status with waitrequest low, zero wait states.
  - Status = {engine_busy, 3'b0, fifo_count[3:0]}.
- Reads with address[0]=1 hold waitrequest high until the FIFO is empty and the engine is in IDLE. The engine then runs one panel read cycle with RS = address[1].
- Engine FSM:
  - IDLE → SETUP on FIFO non-empty (pop) or a pending panel read. Writes have priority over reads.
  - SETUP (TAS_CYC cycles; RS/RW/data driven, E=0) → PULSE.
  - PULSE (PW_CYC cycles, E=1). For a panel read, LCD_data is sampled into readdata on the last PULSE cycle.
  - PULSE → HOLD (TH_CYC cycles, E=0, signals held).
  - HOLD → EXEC_WAIT for writes; → IDLE for reads.
  - EXEC_WAIT counts CLR_CYC if RS=0 and byte ∈ {0x01,0x02,0x03}, else EXEC_CYC; then → IDLE.
- In IDLE: LCD_RW=1 and the bus is tri-stated; RS is held at the last value.
- Delay counter width = clog2(max(CLR_CYC, PW_CYC)+1).
- engine_busy = state ≠ IDLE.

## Timing
- Reset values:
  - LCD_E=0, LCD_RS=0, LCD_RW=1.
  - LCD_data tri-stated.
  - readdata=0x00, waitrequest=0.
  - FIFO empty, state IDLE.
- Write latency: a write accepted in cycle T with engine idle and FIFO empty pops at T+1. RS/RW/data are valid from T+2, and LCD_E rises at T+2+TAS_CYC.
- Back-to-back writes: LCD_E rising edges are spaced TAS_CYC+PW_CYC+TH_CYC+EXEC_CYC cycles apart.
- Panel read: waitrequest deasserts for exactly one cycle, the cycle after HOLD ends, with readdata valid in that cycle.
- FIFO full:
  - Push and pop in the same cycle: push is stalled, pop proceeds.
  - FIFO empty: pop never occurs.
- read and write asserted together is illegal; the write is taken and the read ignored.
- Asynchronous reset mid-access drops LCD_E immediately, flushes the FIFO and discards any pending read.

## Configuration
- LCD_BUSY_POLL_EN defined:
  - EXEC_WAIT is replaced by POLL. POLL runs SETUP/PULSE/HOLD read cycles with RS=0, RW=1, repeating until the sampled DB7=0, then → IDLE.
  - Polling aborts to IDLE after CLR_CYC total cycles.
  - Status bit6 = poll_timeout sticky flag, cleared by a status read.
- LCD_BUSY_POLL_EN undefined: fixed EXEC_CYC/CLR_CYC delays as above; status bit6 = 0.

## Structure
- Package lcd_ctrl_pkg:
  - state enum;
  - status bit positions;
  - clear/home opcode constants;
  - is_slow_cmd(rs, byte) function.
- Sub-module lcd_cmd_fifo: synchronous FIFO, 9-bit entries, FIFO_DEPTH, full/empty/count outputs, asynchronous active-high reset.
- Top level holds the FSM, delay counter, tri-state and Avalon decode.

## Test plan
- Reset, then write 0x38 at address 0 → waitrequest low. LCD_RS=0 and LCD_data=0x38 from T+2; LCD_E high for exactly 12 cycles starting at T+5.
- Write 0x01 then 0x41 at address 2 → second LCD_E rise occurs 3+12+2+82000 cycles after the first; RS=1 on the second access.
- 10 back-to-back writes with FIFO_DEPTH=8 → waitrequest asserted on the 10th write until the first pop frees a slot; all 10 bytes appear on the panel bus in order.
- Panel read at address 3 with the model driving 0x5A while FIFO holds 2 entries → waitrequest high until both writes and the read cycle finish; readdata=0x5A for one cycle.
- Status read mid-burst → bit7=1, count matches FIFO occupancy. Assert reset during PULSE → LCD_E=0 in the same cycle, status reads 0x00 afterwards.
- With LCD_BUSY_POLL_EN: model holds DB7=1 for 3 polls, then 0 → exactly 4 poll E pulses, then IDLE. Model holds DB7=1 permanently → timeout after CLR_CYC cycles, status bit6=1.

Source files
------------

// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg: shared engine states, status bit positions and HD44780 slow-opcode helper
package lcd_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC_WAIT, POLL} state_t;
  localparam int ST_BUSY = 7;
  localparam int ST_POLL_TO = 6;
  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] OP_HOME = 8'h02;
  localparam logic [7:0] OP_HOME_ALT = 8'h03;
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] b);
    return !rs && (b == OP_CLEAR || b == OP_HOME || b == OP_HOME_ALT);
  endfunction
endpackage

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: {rs, byte} posted-write FIFO with occupancy count, async active-high reset
module lcd_cmd_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [8:0] din,
  output logic [8:0] dout,
  output logic       full,
  output logic       empty,
  output logic [3:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [8:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign full = count == 4'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= !do_push ? wp : wp == AW'(DEPTH - 1) ? '0 : wp + AW'(1);
      rp <= !do_pop ? rp : rp == AW'(DEPTH - 1) ? '0 : rp + AW'(1);
      count <= count + 4'(do_push) - 4'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/lcd_timing_ctrl.sv
// lcd_timing_ctrl: Avalon-MM HD44780 controller; FIFO-posted writes paced by setup/pulse/hold/exec timing.
// Define LCD_BUSY_POLL_EN to replace fixed execution delays with busy-flag polling.
module lcd_timing_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int TAS_CYC    = 3,
  parameter int PW_CYC     = 12,
  parameter int TH_CYC     = 2,
  parameter int EXEC_CYC   = 2500,
  parameter int CLR_CYC    = 82000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] address,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_data
);
  localparam int MAXD = CLR_CYC > PW_CYC ? CLR_CYC : PW_CYC;
  localparam int CW = $clog2(MAXD + 1);
  state_t state, state_nxt;
  logic [CW-1:0] cnt, dur;
  logic [8:0] fifo_dout;
  logic [3:0] fifo_count;
  logic [7:0] cur_data, status;
  logic fifo_full, fifo_empty, push, pop, rd_pend, rd_op, rd_done, cur_rs, cur_rw, last, poll_to;
  assign push = write & ~address[0];
  assign rd_pend = read & ~write & address[0] & ~rd_done;
  assign waitrequest = (write & fifo_full) | rd_pend;
  assign last = cnt == '0;
  assign pop = state == IDLE & ~fifo_empty;
  assign LCD_E = state == PULSE;
  assign LCD_RS = cur_rs;
  assign LCD_RW = cur_rw | !(state inside {SETUP, PULSE, HOLD});
  assign LCD_data = LCD_RW ? 8'bz : cur_data;
  lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(reset), .push(push), .pop(pop), .din({address[1], writedata}),
    .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
  );
  always_comb begin
    status = {4'b0, fifo_count};
    status[ST_BUSY] = state != IDLE;
    status[ST_POLL_TO] = poll_to;
  end
`ifdef LCD_BUSY_POLL_EN
  logic polling, busy_q, abort, stat_rd;
  logic [CW-1:0] poll_tmr;
  assign stat_rd = read & ~write & ~address[0];
  assign abort = polling && poll_tmr == CW'(CLR_CYC - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      polling <= 1'b0;
      busy_q <= 1'b0;
      poll_tmr <= '0;
      poll_to <= 1'b0;
    end else begin
      polling <= state_nxt == POLL ? 1'b1 : state_nxt == IDLE ? 1'b0 : polling;
      busy_q <= (state == PULSE && last) ? LCD_data[7] : busy_q;
      poll_tmr <= polling ? poll_tmr + CW'(1) : '0;
      // only clear the sticky flag once software has actually been shown it
      poll_to <= abort ? 1'b1 : (stat_rd && readdata[ST_POLL_TO]) ? 1'b0 : poll_to;
    end
`else
  assign poll_to = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = (!fifo_empty || rd_pend) ? SETUP : IDLE;
      SETUP:     state_nxt = last ? PULSE : SETUP;
      PULSE:     state_nxt = last ? HOLD : PULSE;
`ifdef LCD_BUSY_POLL_EN
      HOLD:      state_nxt = !last ? HOLD : rd_op ? IDLE : (polling && !busy_q) ? IDLE : POLL;
      POLL:      state_nxt = SETUP;
`else
      HOLD:      state_nxt = !last ? HOLD : rd_op ? IDLE : EXEC_WAIT;
`endif
      EXEC_WAIT: state_nxt = last ? IDLE : EXEC_WAIT;
      default:   state_nxt = IDLE;
    endcase
`ifdef LCD_BUSY_POLL_EN
    if (abort) state_nxt = IDLE;
`endif
  end
  // exec wait is one short: the IDLE pop cycle completes the post-access delay
  assign dur = state_nxt == SETUP ? CW'(TAS_CYC - 1) :
               state_nxt == PULSE ? CW'(PW_CYC - 1) :
               state_nxt == HOLD  ? CW'(TH_CYC - 1) :
               state_nxt == EXEC_WAIT ? (is_slow_cmd(cur_rs, cur_data) ? CW'(CLR_CYC - 2) : CW'(EXEC_CYC - 2)) : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      cur_rs <= 1'b0;
      cur_rw <= 1'b1;
      cur_data <= '0;
      rd_op <= 1'b0;
      rd_done <= 1'b0;
      readdata <= '0;
    end else begin
      cnt <= state_nxt != state ? dur : last ? cnt : cnt - CW'(1);
      rd_done <= state == HOLD && last && rd_op;
      if (pop) begin
        cur_rs <= fifo_dout[8];
        cur_data <= fifo_dout[7:0];
        cur_rw <= 1'b0;
      end else if (state == IDLE && rd_pend) begin
        cur_rs <= address[1];
        cur_rw <= 1'b1;
        rd_op <= 1'b1;
      end else if (state == POLL) begin
        cur_rs <= 1'b0;
        cur_rw <= 1'b1;
      end
      if (state == HOLD && last) rd_op <= 1'b0;
      // panel read data is held from capture until the completing bus cycle
      if (state == PULSE && last && rd_op) readdata <= LCD_data;
      else if (!rd_op && !rd_done) readdata <= status;
    end
endmodule
